// File: rtl/rtc_load_resp.sv
// RTC-domain responder for the pclk load/clear 4-phase handshake.
// Owns the free-running RTC counter and its sticky compare-match interrupt.
module rtc_load_resp #(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_CNT = '0
) (
  input  logic             rtc_clk,
  input  logic             presetn,
  input  logic             load_req,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cnt_en,
  input  logic [CNT_W-1:0] match_val,
  output logic             load_ack,
  output logic [CNT_W-1:0] rtc_cnt,
  output logic             rtc_match_int,
  output logic             load_busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_e;

  state_e           state_q, state_d;
  logic             req_s1_q, req_s2_q;
  logic             en_s1_q, en_s2_q;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_q, int_d;

  // Two-flop synchronizers for the asynchronous request and enable levels.
  always_ff @(posedge rtc_clk or negedge presetn) begin
    if (!presetn) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      en_s1_q  <= 1'b0;
      en_s2_q  <= 1'b0;
    end else begin
      req_s1_q <= load_req;
      req_s2_q <= req_s1_q;
      en_s1_q  <= cnt_en;
      en_s2_q  <= en_s1_q;
    end
  end

  // A high request seen outside IDLE never starts a new transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_s2_q)  state_d = LOAD;
      LOAD:                   state_d = ACK;
      ACK:     if (!req_s2_q) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Ack and busy are decoded from next state into flops so the
  // cross-domain ack level can never glitch.
  always_comb begin
    ack_d  = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    cnt_d = cnt_q;
    int_d = int_q;
    if (state_q == LOAD) begin
      cnt_d = load_val;
      int_d = 1'b0;
    end else if (en_s2_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == match_val) int_d = 1'b1;
    end
  end

  always_ff @(posedge rtc_clk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= RST_CNT;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
    end
  end

  assign load_ack      = ack_q;
  assign load_busy     = busy_q;
  assign rtc_cnt       = cnt_q;
  assign rtc_match_int = int_q;

endmodule

// File: tb/tb_rtc_load_resp.sv
// Randomized bench for rtc_load_resp against an event/latency-level reference model.
module tb_rtc_load_resp;

  logic        rtc_clk = 1'b0;
  logic        presetn = 1'b0;
  logic        load_req = 1'b0;
  logic        cnt_en = 1'b0;
  logic [31:0] load_val = '0;
  logic [31:0] match_val = '0;
  logic        load_ack;
  logic [31:0] rtc_cnt;
  logic        rtc_match_int;
  logic        load_busy;

  int tests = 0;
  int fails = 0;

  rtc_load_resp #(.CNT_W(32), .RST_CNT(32'h0)) dut (
    .rtc_clk(rtc_clk), .presetn(presetn), .load_req(load_req), .load_val(load_val),
    .cnt_en(cnt_en), .match_val(match_val), .load_ack(load_ack), .rtc_cnt(rtc_cnt),
    .rtc_match_int(rtc_match_int), .load_busy(load_busy)
  );

  always #5 rtc_clk = ~rtc_clk;

  // Reference model: input samples per edge, and handshake milestones as edge numbers
  // derived from the documented latencies (busy at E+2, load/ack at E+3, release F+2).
  int          t;
  bit          req_h [0:255];
  bit          en_h  [0:255];
  bit          m_act;
  int          m_busy_at, m_load_at, m_rel_at;
  logic [31:0] m_cnt;
  bit          m_int;

  function automatic bit m_ack();
    return m_act && (t >= m_load_at);
  endfunction

  function automatic bit m_busy();
    return m_act && (t >= m_busy_at);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin req_h[i] = 1'b0; en_h[i] = 1'b0; end
    t = 8; m_act = 1'b0; m_busy_at = -1; m_load_at = -1; m_rel_at = -1;
    m_cnt = 32'h0; m_int = 1'b0;
  endtask

  task automatic step();
    bit r, e;
    logic [31:0] lv, mv;
    r = load_req; e = cnt_en; lv = load_val; mv = match_val;
    @(posedge rtc_clk); #1;
    t++;
    req_h[t & 255] = r;
    en_h[t & 255]  = e;
    if (m_act && t == m_load_at) begin
      m_cnt = lv; m_int = 1'b0;
    end else if (en_h[(t - 2) & 255]) begin
      if (m_cnt == mv) m_int = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    if (m_act && m_rel_at == t) begin
      m_act = 1'b0; m_rel_at = -1;
    end else if (m_act && m_rel_at < 0 && !r && t + 1 >= m_load_at) begin
      m_rel_at = t + 2;
    end
    if (!m_act && r) begin
      m_act = 1'b1; m_busy_at = t + 2; m_load_at = t + 3; m_rel_at = -1;
    end
  endtask

  task automatic test_reset();
    model_reset();
    presetn = 1'b0;
    #3;
    tests++;
    if (rtc_cnt !== 32'h0 || load_ack !== 1'b0 || rtc_match_int !== 1'b0 || load_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state cnt=%h ack=%b int=%b busy=%b want 0/0/0/0", rtc_cnt, load_ack, rtc_match_int, load_busy);
    end
    #10 presetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if (rtc_cnt !== 32'h0 || load_ack !== 1'b0 || rtc_match_int !== 1'b0 || load_busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_hold cyc=%0d cnt=%h ack=%b int=%b busy=%b want 0/0/0/0", i, rtc_cnt, load_ack, rtc_match_int, load_busy);
      end
    end
  endtask

  task automatic test_load_basic();
    cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    load_val = 32'h1234_5678;
    load_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (i < 4 && load_ack !== 1'b0) begin
        fails++; $display("FAIL load_latency edge=%0d ack=%b want 0", i, load_ack);
      end else if (i == 4 && (load_ack !== 1'b1 || rtc_cnt !== 32'h1234_5678)) begin
        fails++; $display("FAIL load_edge4 ack=%b cnt=%h want 1/12345678", load_ack, rtc_cnt);
      end
    end
    step();
    tests++;
    if (rtc_cnt !== 32'h1234_5679) begin
      fails++; $display("FAIL load_then_count cnt=%h want 12345679", rtc_cnt);
    end
    load_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (load_ack !== (i < 3) || load_busy !== (i < 3)) begin
        fails++; $display("FAIL release_latency edge=%0d ack=%b busy=%b want %0d", i, load_ack, load_busy, i < 3);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [0:3];
    bit done;
    exp_seq[0] = 32'hFFFF_FFFE; exp_seq[1] = 32'hFFFF_FFFF; exp_seq[2] = 32'h0; exp_seq[3] = 32'h1;
    match_val = 32'd5;
    load_val = 32'hFFFF_FFFE;
    load_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      step();
      done = load_ack;
    end
    tests++;
    if (!done) begin fails++; $display("FAIL wrap_ack_timeout ack=%b want 1", load_ack); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      tests++;
      if (rtc_cnt !== exp_seq[i] || rtc_match_int !== 1'b0 || rtc_cnt !== m_cnt) begin
        fails++; $display("FAIL wrap_seq i=%0d cnt=%h int=%b want %h/0", i, rtc_cnt, rtc_match_int, exp_seq[i]);
      end
    end
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (load_ack !== 1'b0 || load_busy !== 1'b0 || rtc_match_int !== 1'b0) begin
      fails++; $display("FAIL wrap_release ack=%b busy=%b int=%b want 0/0/0", load_ack, load_busy, rtc_match_int);
    end
  endtask

  task automatic test_match();
    bit done;
    cnt_en = 1'b0;
    match_val = 32'h10;
    load_val = 32'h0;
    for (int i = 0; i < 3; i++) step();
    load_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin step(); done = load_ack; end
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (!done || rtc_cnt !== 32'h0) begin
      fails++; $display("FAIL match_setup ack_seen=%0d cnt=%h want 1/0", done, rtc_cnt);
    end
    cnt_en = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      done = (rtc_cnt == 32'h10);
      tests++;
      if (rtc_match_int !== 1'b0 || rtc_cnt !== m_cnt) begin
        fails++; $display("FAIL match_early cnt=%h int=%b want %h/0", rtc_cnt, rtc_match_int, m_cnt);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (rtc_match_int !== 1'b1 || rtc_cnt !== 32'h11 + i) begin
        fails++; $display("FAIL match_sticky i=%0d cnt=%h int=%b want %h/1", i, rtc_cnt, rtc_match_int, 32'h11 + i);
      end
    end
    load_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin step(); done = load_ack; end
    tests++;
    if (!done || rtc_match_int !== 1'b0 || rtc_cnt !== 32'h0) begin
      fails++; $display("FAIL match_clear ack_seen=%0d int=%b cnt=%h want 1/0/0", done, rtc_match_int, rtc_cnt);
    end
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_hold();
    bit done;
    logic [31:0] prev;
    load_val = 32'hA5A5_0000;
    match_val = 32'h0;
    load_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin step(); done = load_ack; end
    prev = rtc_cnt;
    for (int i = 0; i < 50; i++) begin
      step();
      tests++;
      if (rtc_cnt !== prev + 32'd1 || load_ack !== 1'b1 || load_busy !== 1'b1) begin
        fails++; $display("FAIL hold_no_reload i=%0d cnt=%h ack=%b busy=%b want %h/1/1", i, rtc_cnt, load_ack, load_busy, prev + 32'd1);
      end
      prev = rtc_cnt;
    end
    load_req = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin step(); done = !load_ack; end
    load_val = 32'h0BAD_F00D;
    load_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin step(); done = load_ack; end
    tests++;
    if (!done || rtc_cnt !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL second_load ack_seen=%0d cnt=%h want 1/0badf00d", done, rtc_cnt);
    end
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_random();
    bit done;
    int gap, extra;
    for (int it = 0; it < 25; it++) begin
      load_val = $urandom;
      match_val = load_val + 32'($urandom_range(0, 6));
      gap = $urandom_range(0, 5);
      for (int g = 0; g <= gap; g++) begin
        cnt_en = ($urandom_range(0, 3) != 0);
        step();
        tests++;
        if (rtc_cnt !== m_cnt || load_ack !== m_ack() || load_busy !== m_busy() || rtc_match_int !== m_int) begin
          fails++;
          $display("FAIL rand_model t=%0d cnt=%h/%h ack=%b/%b busy=%b/%b int=%b/%b", t, rtc_cnt, m_cnt, load_ack, m_ack(), load_busy, m_busy(), rtc_match_int, m_int);
        end
      end
      load_req = 1'b1;
      extra = $urandom_range(0, 6);
      done = 1'b0;
      for (int k = 0; k < 30 && (!done || extra > 0); k++) begin
        if (done) extra--;
        cnt_en = ($urandom_range(0, 3) != 0);
        step();
        done = done || m_ack();
        tests++;
        if (rtc_cnt !== m_cnt || load_ack !== m_ack() || load_busy !== m_busy() || rtc_match_int !== m_int) begin
          fails++;
          $display("FAIL rand_model t=%0d cnt=%h/%h ack=%b/%b busy=%b/%b int=%b/%b", t, rtc_cnt, m_cnt, load_ack, m_ack(), load_busy, m_busy(), rtc_match_int, m_int);
        end
      end
      load_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
        cnt_en = ($urandom_range(0, 3) != 0);
        step();
        tests++;
        if (rtc_cnt !== m_cnt || load_ack !== m_ack() || load_busy !== m_busy() || rtc_match_int !== m_int) begin
          fails++;
          $display("FAIL rand_model t=%0d cnt=%h/%h ack=%b/%b busy=%b/%b int=%b/%b", t, rtc_cnt, m_cnt, load_ack, m_ack(), load_busy, m_busy(), rtc_match_int, m_int);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit done;
    cnt_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    load_val = 32'h0000_0100;
    match_val = 32'h0000_0102;
    load_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin step(); done = load_ack; end
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (load_ack !== 1'b1 || rtc_match_int !== 1'b1 || load_busy !== 1'b1) begin
      fails++; $display("FAIL pre_reset_ack ack=%b int=%b busy=%b want 1/1/1", load_ack, rtc_match_int, load_busy);
    end
    #2 presetn = 1'b0;
    #1;
    tests++;
    if (load_ack !== 1'b0 || load_busy !== 1'b0 || rtc_cnt !== 32'h0 || rtc_match_int !== 1'b0) begin
      fails++; $display("FAIL async_reset ack=%b busy=%b cnt=%h int=%b want 0/0/0/0", load_ack, load_busy, rtc_cnt, rtc_match_int);
    end
    model_reset();
    load_req = 1'b0;
    #2 presetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (rtc_cnt !== m_cnt || load_ack !== m_ack() || load_busy !== m_busy() || rtc_match_int !== m_int) begin
        fails++;
        $display("FAIL post_reset t=%0d cnt=%h/%h ack=%b/%b busy=%b/%b int=%b/%b", t, rtc_cnt, m_cnt, load_ack, m_ack(), load_busy, m_busy(), rtc_match_int, m_int);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wrap();
    test_match();
    test_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
